alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: DEPTH, 4, result-buffer entries; power of two, minimum 2.
REQ-002 Parameter: CW, 16, width of the statistic counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  the upstream ALU result and opcode are valid this cycle.
REQ-006 in_ready  output  1  stage can accept an entry this cycle.
REQ-007 in_result  input  33  ALU result; bit 32 is the carry/borrow out.
REQ-008 in_opcode  input  4  opcode that produced in_result.
REQ-009 out_valid  output  1  head entry is valid.
REQ-010 out_ready  input  1  consumer takes the head entry this cycle.
REQ-011 out_data  output  32  head result bits [31:0].
REQ-012 out_opcode  output  4  head opcode.
REQ-013 out_carry  output  1  head carry flag.
REQ-014 out_zero  output  1  head zero flag.
REQ-015 out_neg  output  1  head negative flag.
REQ-016 level  output  log2(DEPTH)+1  number of occupied entries.
REQ-017 carry_cnt  output  CW  count of accepted entries with carry flag set.
REQ-018 drop_cnt  output  CW  count of discarded entries with an illegal opcode.

Function
REQ-019 Accept (handshake) SHALL occur when in_valid=1 and in_ready=1; pop SHALL occur when out_valid=1 and out_ready=1.
REQ-020 in_ready SHALL equal (level != DEPTH); it SHALL NOT depend on out_ready in the same cycle.
REQ-021 Legal opcodes SHALL be 4'h1 to 4'h7; any other accepted opcode SHALL NOT be written into the buffer and SHALL increment drop_cnt.
REQ-022 Flags SHALL be computed at accept time and stored with the entry.
REQ-023 Flag carry SHALL be in_result[32] for opcodes 4'h1 (add) and 4'h2 (sub/borrow); it SHALL be 0 for all other opcodes.
REQ-024 Flag zero SHALL be (in_result[31:0]==0).
REQ-025 Flag neg SHALL be in_result[31].
REQ-026 Latency: an entry accepted at edge N into an empty buffer SHALL drive out_valid=1 after edge N; there is no combinational fall-through.
REQ-027 Buffer order SHALL be FIFO.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 level SHALL update as: +1 on a legal-opcode push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-030 Simultaneous push and pop at level=DEPTH SHALL NOT occur, because in_ready=0.
REQ-031 Simultaneous push and pop at level=0 SHALL push only; out_valid=0 in that cycle.
REQ-032 out_* data and flag outputs SHALL be driven from the head entry.
REQ-033 out_* data and flag outputs SHALL be 0 when out_valid=0.
REQ-034 carry_cnt and drop_cnt SHALL saturate at all-ones and SHALL NOT wrap.
REQ-035 An illegal-opcode accept with level=DEPTH SHALL NOT happen, because in_ready=0; such an entry stalls upstream like any other.

Reset
REQ-036 rst_n=0 SHALL immediately clear the following, regardless of clk: pointers, level, carry_cnt, drop_cnt, out_valid and all out_* data and flags; in_ready SHALL then be 1.
REQ-037 Reset asserted mid-transfer SHALL discard all buffered entries.
REQ-038 The first accept after reset release SHALL be taken on the first rising edge with rst_n=1.

Verification
REQ-039 Single add: push op 4'h1, result 33'h1_0000_0000 -> after one edge, out_valid=1, data 0, carry=1, zero=1, neg=0, carry_cnt=1.
REQ-040 Fill and backpressure: out_ready=0, push 4 legal entries (5, 6, 7, 8) -> level=4, in_ready=0; fifth push held; then out_ready=1 -> pops in order 5, 6, 7, 8, and level returns to 0.
REQ-041 Illegal opcode: push op 4'h0 then 4'h9 with result 33'h0_8000_0000 -> buffer stays empty, drop_cnt=2, carry_cnt unchanged.
REQ-042 Carry masking: push op 4'h3 with bit32=1 -> carry=0, neg per bit31, carry_cnt unchanged.
REQ-043 Steady stream: push and pop every cycle at level=1 -> level stays 1 and data order is preserved across at least 2*DEPTH pointer wraps.
REQ-044 Reset mid-run: level=3, then rst_n=0 between edges -> out_valid=0, level=0 and counters=0 immediately; after release, a new push appears as head.

Source files
------------

// File: rtl/alu_result_stage.sv
// ALU result buffer: accepts results with a legal opcode, computes carry/zero/neg
// flags at accept time and presents them in FIFO order.
module alu_result_stage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [32:0]            in_result,
    input  logic [3:0]             in_opcode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic [3:0]             out_opcode,
    output logic                   out_carry,
    output logic                   out_zero,
    output logic                   out_neg,
    output logic [$clog2(DEPTH):0] level,
    output logic [CW-1:0]          carry_cnt,
    output logic [CW-1:0]          drop_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [31:0]   mem_data  [DEPTH];
    logic [3:0]    mem_op    [DEPTH];
    logic [2:0]    mem_flags [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic [LW-1:0] level_nxt;
    logic [CW-1:0] carry_cnt_nxt, drop_cnt_nxt;

    logic          accept, legal, push, pop;
    logic          flag_c, flag_z, flag_n;

    // Handshakes and flag computation on the incoming result
    always_comb begin
        in_ready  = (level != LW'(DEPTH));
        out_valid = (level != '0);
        accept    = in_valid && in_ready;
        legal     = (in_opcode >= 4'h1) && (in_opcode <= 4'h7);
        push      = accept && legal;
        pop       = out_valid && out_ready;
        flag_c    = ((in_opcode == 4'h1) || (in_opcode == 4'h2)) && in_result[32];
        flag_z    = (in_result[31:0] == 32'h0);
        flag_n    = in_result[31];
    end

    // Next-state for pointers, occupancy and saturating statistics
    always_comb begin
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        level_nxt     = level;
        carry_cnt_nxt = carry_cnt;
        drop_cnt_nxt  = drop_cnt;

        if (push) begin
            wr_ptr_nxt = wr_ptr + AW'(1);
        end
        if (pop) begin
            rd_ptr_nxt = rd_ptr + AW'(1);
        end
        if (push && !pop) begin
            level_nxt = level + LW'(1);
        end else if (pop && !push) begin
            level_nxt = level - LW'(1);
        end
        if (push && flag_c && (carry_cnt != '1)) begin
            carry_cnt_nxt = carry_cnt + CW'(1);
        end
        if (accept && !legal && (drop_cnt != '1)) begin
            drop_cnt_nxt = drop_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            carry_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            level     <= level_nxt;
            carry_cnt <= carry_cnt_nxt;
            drop_cnt  <= drop_cnt_nxt;
        end
    end

    // Storage needs no reset: contents are masked whenever the buffer is empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr]  <= in_result[31:0];
            mem_op[wr_ptr]    <= in_opcode;
            mem_flags[wr_ptr] <= {flag_c, flag_z, flag_n};
        end
    end

    // Head entry presentation, forced to zero while empty
    always_comb begin
        out_data   = '0;
        out_opcode = '0;
        out_carry  = 1'b0;
        out_zero   = 1'b0;
        out_neg    = 1'b0;
        if (out_valid) begin
            out_data   = mem_data[rd_ptr];
            out_opcode = mem_op[rd_ptr];
            out_carry  = mem_flags[rd_ptr][2];
            out_zero   = mem_flags[rd_ptr][1];
            out_neg    = mem_flags[rd_ptr][0];
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed and random checks of alu_result_stage against a queue-based model.
module tb_alu_result_stage;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  op;
        logic        c;
        logic        z;
        logic        n;
    } ent_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [32:0]   in_result;
    logic [3:0]    in_opcode;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [3:0]    out_opcode;
    logic          out_carry;
    logic          out_zero;
    logic          out_neg;
    logic [LW-1:0] level;
    logic [CW-1:0] carry_cnt;
    logic [CW-1:0] drop_cnt;

    ent_t          q[$];
    logic [CW-1:0] m_carry;
    logic [CW-1:0] m_drop;
    int            checks;
    int            errors;

    alu_result_stage #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_opcode (in_opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_opcode(out_opcode),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .level     (level),
        .carry_cnt (carry_cnt),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Score the current inputs against the model, advance one edge, check state
    task automatic cycle();
        logic acc;
        logic pop;
        ent_t e;
        ent_t h;
        pop = out_ready && (q.size() != 0);
        acc = in_valid && (q.size() != DEPTH);
        if (pop) begin
            h = q.pop_front();
            chk("head_data", 64'(out_data), 64'(h.d));
            chk("head_op", 64'(out_opcode), 64'(h.op));
            chk("head_flags", 64'({out_carry, out_zero, out_neg}), 64'({h.c, h.z, h.n}));
        end
        if (acc) begin
            if (in_opcode >= 4'h1 && in_opcode <= 4'h7) begin
                e.d  = in_result[31:0];
                e.op = in_opcode;
                e.c  = (in_opcode == 4'h1 || in_opcode == 4'h2) ? in_result[32] : 1'b0;
                e.z  = (in_result[31:0] == 32'h0);
                e.n  = in_result[31];
                q.push_back(e);
                if (e.c && m_carry != '1) m_carry = m_carry + CW'(1);
            end else if (m_drop != '1) begin
                m_drop = m_drop + CW'(1);
            end
        end
        @(posedge clk);
        #1;
        chk("level", 64'(level), 64'(q.size()));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
        chk("carry_cnt", 64'(carry_cnt), 64'(m_carry));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (q.size() == 0)
            chk("idle_zero", 64'({out_data, out_opcode, out_carry, out_zero, out_neg}), 64'(0));
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [32:0] r, input logic rdy);
        in_valid  = v;
        in_opcode = op;
        in_result = r;
        out_ready = rdy;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH && q.size() != 0; i++) cycle();
        chk("drain_empty", 64'(level), 64'(0));
        out_ready = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_carry = '0;
        m_drop  = '0;
        rst_n   = 1'b0;
        drive(1'b0, 4'h0, 33'h0, 1'b0);
        #12;
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        rst_n = 1'b1;

        // Single add with carry out and zero result, taken on first edge
        drive(1'b1, 4'h1, 33'h1_0000_0000, 1'b0);
        cycle();
        in_valid = 1'b0;
        chk("add_valid", 64'(out_valid), 64'(1));
        chk("add_data", 64'(out_data), 64'(0));
        chk("add_czn", 64'({out_carry, out_zero, out_neg}), 64'(3'b110));
        chk("add_carry_cnt", 64'(carry_cnt), 64'(1));
        drain();

        // Illegal opcodes are dropped
        drive(1'b1, 4'h0, 33'h0_8000_0000, 1'b0);
        cycle();
        drive(1'b1, 4'h9, 33'h0_8000_0000, 1'b0);
        cycle();
        in_valid = 1'b0;
        chk("ill_level", 64'(level), 64'(0));
        chk("ill_drop", 64'(drop_cnt), 64'(2));
        chk("ill_carry", 64'(carry_cnt), 64'(1));

        // Carry masked for non add/sub opcode
        drive(1'b1, 4'h3, 33'h1_8000_0001, 1'b0);
        cycle();
        in_valid = 1'b0;
        chk("mask_czn", 64'({out_carry, out_zero, out_neg}), 64'(3'b001));
        chk("mask_carry_cnt", 64'(carry_cnt), 64'(1));
        drain();

        // Fill and backpressure
        for (int i = 5; i <= 8; i++) begin
            drive(1'b1, 4'h4, 33'(i), 1'b0);
            cycle();
        end
        chk("full_level", 64'(level), 64'(DEPTH));
        chk("full_ready", 64'(in_ready), 64'(0));
        drive(1'b1, 4'h4, 33'd9, 1'b0);
        cycle();
        cycle();
        chk("held_level", 64'(level), 64'(DEPTH));
        chk("held_head", 64'(out_data), 64'(5));
        drain();

        // Steady stream at level 1 across many wraps
        drive(1'b1, 4'h2, 33'h1_0000_0100, 1'b0);
        cycle();
        for (int i = 0; i < 2 * DEPTH * DEPTH + 2; i++) begin
            drive(1'b1, 4'(1 + (i % 7)), {1'(i & 1), 32'h1000 + 32'(i)}, 1'b1);
            cycle();
            chk("stream_level", 64'(level), 64'(1));
        end
        drain();

        // Random traffic including illegal opcodes and counter saturation
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  {1'($urandom_range(0, 1)), 32'($urandom)}, 1'($urandom_range(0, 1)));
            cycle();
        end
        drain();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 4'hf, 33'h0, 1'b0);
            cycle();
        end
        chk("drop_sat", 64'(drop_cnt), 64'({CW{1'b1}}));

        // Reset mid-run discards contents immediately
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'h1, 33'h1_0000_0020 + 33'(i), 1'b0);
            cycle();
        end
        in_valid = 1'b0;
        chk("pre_rst_level", 64'(level), 64'(3));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_level", 64'(level), 64'(0));
        chk("mid_rst_cnts", 64'({carry_cnt, drop_cnt}), 64'(0));
        chk("mid_rst_ready", 64'(in_ready), 64'(1));
        chk("mid_rst_data", 64'(out_data), 64'(0));
        q.delete();
        m_carry = '0;
        m_drop  = '0;
        #2;
        rst_n = 1'b1;
        drive(1'b1, 4'h2, 33'h1_0000_0003, 1'b0);
        cycle();
        in_valid = 1'b0;
        chk("post_rst_head", 64'(out_data), 64'(3));
        chk("post_rst_carry", 64'(out_carry), 64'(1));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
